// File: rtl/morra_pkg.sv
// morra_host shared types.
// Move/outcome encodings and host FSM states.
package morra_pkg;

  typedef enum logic [1:0] {
    MV_NONE    = 2'b00,
    MV_SASSO   = 2'b01,
    MV_CARTA   = 2'b10,
    MV_FORBICE = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    OC_NONE = 2'b00,
    OC_P1   = 2'b01,
    OC_P2   = 2'b10,
    OC_DRAW = 2'b11
  } outcome_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_COLLECT,
    S_ISSUE,
    S_SAMPLE,
    S_DONE
  } host_state_t;

  // match length is MIN_ROUNDS + cfg_len, enforced by the game FSM
  localparam int MIN_ROUNDS = 4;

endpackage

// File: rtl/morra_if.sv
// Player-side move handshakes for morra_host.
// master = players, slave = host.
interface morra_if;
  logic       p1_valid;
  logic [1:0] p1_move;
  logic       p1_ready;
  logic       p2_valid;
  logic [1:0] p2_move;
  logic       p2_ready;

  modport master (
    output p1_valid, p1_move,
    output p2_valid, p2_move,
    input  p1_ready, p2_ready
  );

  modport slave (
    input  p1_valid, p1_move,
    input  p2_valid, p2_move,
    output p1_ready, p2_ready
  );
endinterface

// File: rtl/morra_move_slot.sv
// One-entry move buffer with illegal-move filter.
// A 00 move is consumed but never stored.
module morra_move_slot
  import morra_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coll,
  input  logic       drop,
  input  logic       clr,
  input  logic       valid,
  input  logic [1:0] move,
  output logic       ready,
  output logic       full,
  output logic       fill,
  output logic       err,
  output logic [1:0] data
);
  logic take;
  logic bad;

  assign ready = coll && !full;
  assign take  = valid && ready && !drop;
  assign bad   = take && (move_t'(move) == MV_NONE);
  assign fill  = full || (take && !bad);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= 2'b00;
      err  <= 1'b0;
    end else begin
      err <= bad;
      if (clr) begin
        full <= 1'b0;
      end else if (take && !bad) begin
        full <= 1'b1;
        data <= move;
      end
    end
  end
endmodule

// File: rtl/morra_host.sv
// Morra game host: pairs player moves into rounds,
// drives the game FSM and tallies results.
module morra_host
  import morra_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       cfg_len,
  morra_if.slave           pl,
  output logic             INIZIO,
  output logic [1:0]       PRIMO,
  output logic [1:0]       SECONDO,
  input  logic [1:0]       MANCHE,
  input  logic [1:0]       PARTITA,
  output logic             res_valid,
  output logic [1:0]       res_manche,
  output logic [1:0]       res_partita,
  output logic [CNT_W-1:0] round_cnt,
  output logic [CNT_W-1:0] score_p1,
  output logic [CNT_W-1:0] score_p2,
  output logic             move_err,
  output logic             done
);
  localparam logic [CNT_W-1:0] CMAX = '1;

  host_state_t state, nxt;
  logic [3:0]  cfg_q;
  logic        coll, clr, sample;
  logic        f1, f2, n1, n2, e1, e2;
  logic [1:0]  d1, d2;

  assign coll   = (state == S_COLLECT);
  assign clr    = start || (state == S_ISSUE);
  assign sample = (state == S_SAMPLE) && !start;

  morra_move_slot u_s1 (
    .clk(clk), .rst_n(rst_n),
    .coll(coll), .drop(start), .clr(clr),
    .valid(pl.p1_valid), .move(pl.p1_move),
    .ready(pl.p1_ready), .full(f1), .fill(n1),
    .err(e1), .data(d1)
  );

  morra_move_slot u_s2 (
    .clk(clk), .rst_n(rst_n),
    .coll(coll), .drop(start), .clr(clr),
    .valid(pl.p2_valid), .move(pl.p2_move),
    .ready(pl.p2_ready), .full(f2), .fill(n2),
    .err(e2), .data(d2)
  );

  assign move_err = e1 || e2;
  assign done     = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // game lines decode from state so reset drops them at once
  always_comb begin
    nxt     = state;
    INIZIO  = 1'b0;
    PRIMO   = 2'b00;
    SECONDO = 2'b00;
    unique case (state)
      S_INIT: begin
        INIZIO           = 1'b1;
        {SECONDO, PRIMO} = cfg_q;
        nxt              = S_COLLECT;
      end
      S_COLLECT: begin
        if (n1 && n2) nxt = S_ISSUE;
      end
      S_ISSUE: begin
        PRIMO   = d1;
        SECONDO = d2;
        nxt     = S_SAMPLE;
      end
      S_SAMPLE: begin
        nxt = (PARTITA != OC_NONE) ? S_DONE : S_COLLECT;
      end
      default: ;
    endcase
    if (start) nxt = S_INIT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q       <= 4'd0;
      res_valid   <= 1'b0;
      res_manche  <= 2'b00;
      res_partita <= 2'b00;
      round_cnt   <= '0;
      score_p1    <= '0;
      score_p2    <= '0;
    end else begin
      res_valid <= sample;
      if (start) begin
        cfg_q     <= cfg_len;
        round_cnt <= '0;
        score_p1  <= '0;
        score_p2  <= '0;
      end else if (sample) begin
        res_manche  <= MANCHE;
        res_partita <= PARTITA;
        if (MANCHE != OC_NONE && round_cnt != CMAX)
          round_cnt <= round_cnt + CNT_W'(1);
        if (MANCHE == OC_P1 && score_p1 != CMAX)
          score_p1 <= score_p1 + CNT_W'(1);
        if (MANCHE == OC_P2 && score_p2 != CMAX)
          score_p2 <= score_p2 + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_morra_host.sv
// Scoreboard bench for morra_host.
// Stimulus pushes expectations; a negedge monitor pops them.
module tb_morra_host;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] cfg_len = 4'd0;
  logic [1:0] MANCHE = 2'b00;
  logic [1:0] PARTITA = 2'b00;
  logic       INIZIO;
  logic [1:0] PRIMO, SECONDO;
  logic       res_valid;
  logic [1:0] res_manche, res_partita;
  logic [4:0] round_cnt, score_p1, score_p2;
  logic       move_err, done;

  morra_if pl();

  morra_host #(.CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_len(cfg_len), .pl(pl),
    .INIZIO(INIZIO), .PRIMO(PRIMO), .SECONDO(SECONDO),
    .MANCHE(MANCHE), .PARTITA(PARTITA),
    .res_valid(res_valid), .res_manche(res_manche),
    .res_partita(res_partita), .round_cnt(round_cnt),
    .score_p1(score_p1), .score_p2(score_p2),
    .move_err(move_err), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] m;
    logic [1:0] p;
    int rc, s1, s2, due;
  } res_t;

  res_t       rq[$];
  logic [3:0] iq[$];
  logic [3:0] sq[$];
  int checks = 0;
  int errors = 0;
  int merr = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // monitor: pop and compare whenever the DUT presents something
  res_t       r;
  logic [3:0] e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (move_err) merr++;
      if (INIZIO) begin
        if (iq.size() == 0) chk("unexpected_init", 1, 0);
        else begin
          e = iq.pop_front();
          chk("init_lines", {SECONDO, PRIMO}, e);
        end
      end else if (PRIMO != 2'b00 || SECONDO != 2'b00) begin
        if (sq.size() == 0) chk("unexpected_issue", 1, 0);
        else begin
          e = sq.pop_front();
          chk("issue_moves", {SECONDO, PRIMO}, e);
        end
      end
      if (res_valid) begin
        if (rq.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          r = rq.pop_front();
          chk("res_manche", res_manche, r.m);
          chk("res_partita", res_partita, r.p);
          chk("round_cnt", round_cnt, r.rc);
          chk("score_p1", score_p1, r.s1);
          chk("score_p2", score_p2, r.s2);
          chk("res_cycle", cyc, r.due);
        end
      end
    end
  end

  task automatic p1_offer(input logic [1:0] m, input int d, output int xc);
    repeat (d) @(negedge clk);
    pl.p1_valid = 1'b1;
    pl.p1_move  = m;
    xc = -1;
    for (int i = 0; i < 40; i++) begin
      if (pl.p1_ready) begin
        xc = cyc;
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    #1;
    pl.p1_valid = 1'b0;
    pl.p1_move  = 2'b00;
    if (xc < 0) chk("p1_timeout", 0, 1);
  endtask

  task automatic p2_offer(input logic [1:0] m, input int d, output int xc);
    repeat (d) @(negedge clk);
    pl.p2_valid = 1'b1;
    pl.p2_move  = m;
    xc = -1;
    for (int i = 0; i < 40; i++) begin
      if (pl.p2_ready) begin
        xc = cyc;
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    #1;
    pl.p2_valid = 1'b0;
    pl.p2_move  = 2'b00;
    if (xc < 0) chk("p2_timeout", 0, 1);
  endtask

  task automatic do_start(input logic [3:0] c);
    iq.push_back(c);
    cfg_len = c;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic round(
    input logic [1:0] m1, input logic [1:0] m2,
    input int d1, input int d2,
    input logic [1:0] man, input logic [1:0] par,
    input int rc, input int s1, input int s2
  );
    int x1, x2;
    res_t n;
    MANCHE  = man;
    PARTITA = par;
    sq.push_back({m2, m1});
    fork
      p1_offer(m1, d1, x1);
      p2_offer(m2, d2, x2);
    join
    n.m   = man;
    n.p   = par;
    n.rc  = rc;
    n.s1  = s1;
    n.s2  = s2;
    n.due = ((x1 > x2) ? x1 : x2) + 3;
    rq.push_back(n);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int x;
    pl.p1_valid = 1'b0;
    pl.p1_move  = 2'b00;
    pl.p2_valid = 1'b0;
    pl.p2_move  = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_inizio", INIZIO, 0);
    chk("rst_lines", {SECONDO, PRIMO}, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res", {res_partita, res_manche}, 0);
    chk("rst_cnt", round_cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", {pl.p2_ready, pl.p1_ready}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {pl.p2_ready, pl.p1_ready}, 0);

    do_start(4'd0);
    @(negedge clk);
    chk("init_one_cycle", INIZIO, 0);
    round(2'b10, 2'b01, 0, 3, 2'b01, 2'b00, 1, 1, 0);

    p1_offer(2'b00, 0, x);
    @(negedge clk);
    chk("p1_ready_after_00", pl.p1_ready, 1);
    repeat (3) @(negedge clk);
    chk("move_err_count", merr, 1);

    round(2'b01, 2'b11, 0, 0, 2'b00, 2'b00, 1, 1, 0);
    chk("ready_reassert", {pl.p2_ready, pl.p1_ready}, 2'b11);

    round(2'b11, 2'b01, 1, 0, 2'b10, 2'b10, 2, 1, 1);
    repeat (3) @(negedge clk);
    chk("done_set", done, 1);
    chk("done_ready", {pl.p2_ready, pl.p1_ready}, 0);

    do_start(4'd6);
    chk("restart_cnt", round_cnt, 0);
    chk("restart_scores", {score_p2, score_p1}, 0);
    chk("restart_done", done, 0);
    @(negedge clk);
    round(2'b01, 2'b10, 1, 0, 2'b11, 2'b00, 1, 0, 0);

    MANCHE = 2'b01;
    sq.push_back({2'b10, 2'b11});
    fork
      p1_offer(2'b11, 0, x);
      p2_offer(2'b10, 0, x);
    join
    @(negedge clk);
    @(negedge clk);
    do_start(4'd3);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_cnt", round_cnt, 0);
    repeat (3) @(negedge clk);

    p1_offer(2'b01, 0, x);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_inizio", INIZIO, 0);
    chk("arst_ready", {pl.p2_ready, pl.p1_ready}, 0);
    chk("arst_res_valid", res_valid, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", {pl.p2_ready, pl.p1_ready}, 0);
    chk("post_rst_lines", {INIZIO, SECONDO, PRIMO}, 0);

    chk("left_results", rq.size(), 0);
    chk("left_issues", sq.size(), 0);
    chk("left_inits", iq.size(), 0);
    chk("move_err_total", merr, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
